shift_accumulator: RTL
======================

Name: shift_accumulator

Overview:
- Accumulates a stream of signed, shift-weighted partial products into one wide signed sum per packet.
- Each packet is one dot-product fragment; the sum is presented on a valid/ready output.
- Sits directly downstream of the fusion-unit multipliers. Each input beat carries a narrow product plus a shift index selecting its bit-position weight.
- Emits one ACC_WIDTH result per packet, with a sticky overflow flag, to the output buffer.

Parameters:
- IN_WIDTH, 8, width of the signed partial-product input.
- ACC_WIDTH, 32, width of the accumulator and result. Must be greater than IN_WIDTH.
- SHIFT_WIDTH, 3, width of the shift-index input.
- SHIFT_AMOUNT, 2, bit positions per shift-index step. Effective shift is in_shift*SHIFT_AMOUNT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  IN_WIDTH  signed partial product.
- in_shift  in  SHIFT_WIDTH  shift index for this beat.
- in_last  in  1  final beat of the packet.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  ACC_WIDTH  signed accumulated result.
- out_overflow  out  1  sticky: overflow occurred anywhere in this packet.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset state:
  - State is IDLE.
  - Accumulator = 0, overflow sticky = 0.
  - out_valid = 0, out_data = 0, out_overflow = 0.
  - in_ready = 1 immediately after reset deasserts.
- Reset mid-packet discards the partial sum. No result is emitted for that packet.
- Transfers:
  - Input accepted when in_valid & in_ready.
  - Output consumed when out_valid & out_ready.
- Term generation:
  - term = sign-extend(in_data) to ACC_WIDTH, then arithmetic left shift by in_shift*SHIFT_AMOUNT.
  - Bits shifted past ACC_WIDTH are dropped.
  - Term overflow = any dropped bit, or the resulting sign bit, differs from the in_data sign.
  - An effective shift >= ACC_WIDTH gives term = 0. Term overflow is then set if in_data != 0.
- Addition: two's-complement wrap at ACC_WIDTH. Add overflow = both operands share a sign and the sum's sign differs.
- States:
  - IDLE: no open packet. On accept: acc <= term; sticky <= term_ovf. Next state is ACCUM, or HOLD if in_last.
  - ACCUM: on accept: acc <= acc + term; sticky |= term_ovf | add_ovf. On in_last, next state is HOLD. No accept means hold all values.
  - HOLD:
    - out_valid = 1; out_data and out_overflow are the registered final acc and sticky.
    - Both are stable until consumed (valid/ready rule).
    - On output handshake with no input accept: go to IDLE; out_valid = 0 next cycle.
- in_ready = (state != HOLD) | out_ready. A beat accepted in HOLD always coincides with the output handshake.
- Simultaneous handshake in HOLD:
  - The accepted beat starts a fresh packet (IDLE rule; the old acc is not added).
  - If that beat has in_last, stay in HOLD with the new result: back-to-back single-beat packets at one per cycle.
- Latency:
  - Result registered on the cycle the last beat is accepted.
  - out_valid is asserted on the following cycle.
- Throughput: one beat per cycle, with no bubble between packets while out_ready = 1.
- out_data and out_overflow retain their last value when out_valid = 0. Only reset zeroes them.

Decomposition:
- Shared package holds:
  - State encoding enum: IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2.
  - Default ACC_WIDTH and SHIFT_AMOUNT constants, shared with the fusion-unit top.
- Sub-module: instantiate the existing combinational `shifter` with IN_WIDTH=IN_WIDTH, OUT_WIDTH=ACC_WIDTH and SHIFT_AMOUNT passed through.
  - Term-overflow detection is local logic beside it.
  - No new sub-module.

Test Plan:
- Basic packet, defaults: beats (3,s0), (-2,s1), (5,s2,last) -> terms 3, -8, 80.
  - out_valid asserts 1 cycle after the last accept.
  - out_data = 75, out_overflow = 0.
- Back-pressure: same packet with out_ready = 0 for 5 cycles.
  - out_valid and out_data = 75 stay stable; in_ready = 0 in HOLD.
  - Releasing out_ready gives exactly one transfer, then IDLE.
- Back-to-back, out_ready = 1: single-beat last packets 1, 2, 3 (s0) on consecutive cycles.
  - Outputs 1, 2, 3 on consecutive cycles; in_ready stays 1.
- Add overflow, ACC_WIDTH=16: four beats (8,s5) -> each term 8192.
  - out_data = 16'h8000 (-32768), out_overflow = 1.
  - The next clean packet (1,s0,last) reports 1 with out_overflow = 0.
- Term overflow, ACC_WIDTH=16: (127,s7) shift 14 drops bits -> out_overflow = 1.
  - (0,s7) gives out_data = 0, overflow 0.
- Reset mid-packet: reset asserted asynchronously after 2 of 3 beats.
  - Outputs zero at once, with no output transfer.
  - After release, packet (4,s0,last) gives out_data = 4.

Source files
------------

// File: rtl/shift_accumulator_pkg.sv
// Types and defaults shared by the shift accumulator and the fusion-unit top.
package shift_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEFAULT_ACC_WIDTH    = 32;
    localparam int DEFAULT_SHIFT_AMOUNT = 2;

endpackage

// File: rtl/shift_accumulator_shifter.sv
// Combinational sign-extending left shifter: result = sext(data) << shift*SHIFT_AMOUNT.
module shifter #(
    parameter int IN_WIDTH     = 8,
    parameter int OUT_WIDTH    = 32,
    parameter int SHIFT_WIDTH  = 3,
    parameter int SHIFT_AMOUNT = 2
) (
    input  logic [IN_WIDTH-1:0]    data,
    input  logic [SHIFT_WIDTH-1:0] shift,
    output logic [OUT_WIDTH-1:0]   result
);

    logic [31:0]          eff_shift;
    logic [OUT_WIDTH-1:0] ext;

    assign eff_shift = 32'(shift) * 32'(SHIFT_AMOUNT);
    assign ext       = {{(OUT_WIDTH-IN_WIDTH){data[IN_WIDTH-1]}}, data};
    // Shifts at or beyond the output width clear the term entirely.
    assign result    = (eff_shift >= 32'(OUT_WIDTH)) ? '0 : (ext << eff_shift);

endmodule

// File: rtl/shift_accumulator.sv
// Accumulates shift-weighted signed partial products into one wide sum per packet,
// with a sticky overflow flag, presented on a valid/ready output.
module shift_accumulator
    import shift_accumulator_pkg::*;
#(
    parameter int IN_WIDTH     = 8,
    parameter int ACC_WIDTH    = DEFAULT_ACC_WIDTH,
    parameter int SHIFT_WIDTH  = 3,
    parameter int SHIFT_AMOUNT = DEFAULT_SHIFT_AMOUNT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_WIDTH-1:0]    in_data,
    input  logic [SHIFT_WIDTH-1:0] in_shift,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_WIDTH-1:0]   out_data,
    output logic                   out_overflow
);

    state_t               state_reg, state_next;
    logic [ACC_WIDTH-1:0] acc_reg, acc_next;
    logic                 sticky_reg, sticky_next;
    logic [ACC_WIDTH-1:0] out_data_reg, out_data_next;
    logic                 out_ovf_reg, out_ovf_next;

    logic [ACC_WIDTH-1:0] term;
    logic [ACC_WIDTH-1:0] ext;
    logic [ACC_WIDTH-1:0] sum;
    logic [31:0]          eff_shift;
    logic                 term_ovf;
    logic                 add_ovf;
    logic                 accept;

    shifter #(
        .IN_WIDTH    (IN_WIDTH),
        .OUT_WIDTH   (ACC_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH),
        .SHIFT_AMOUNT(SHIFT_AMOUNT)
    ) u_shifter (
        .data  (in_data),
        .shift (in_shift),
        .result(term)
    );

    assign eff_shift = 32'(in_shift) * 32'(SHIFT_AMOUNT);
    assign ext       = {{(ACC_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};

    // A term is lossless exactly when shifting it back arithmetically restores sext(in_data).
    assign term_ovf = (eff_shift >= 32'(ACC_WIDTH)) ? (in_data != '0)
                                                    : (($signed(term) >>> eff_shift) != $signed(ext));

    assign sum     = acc_reg + term;
    assign add_ovf = (acc_reg[ACC_WIDTH-1] == term[ACC_WIDTH-1]) &&
                     (sum[ACC_WIDTH-1] != acc_reg[ACC_WIDTH-1]);

    assign in_ready     = (state_reg != HOLD) | out_ready;
    assign accept       = in_valid & in_ready;
    assign out_valid    = (state_reg == HOLD);
    assign out_data     = out_data_reg;
    assign out_overflow = out_ovf_reg;

    always_comb begin
        state_next    = state_reg;
        acc_next      = acc_reg;
        sticky_next   = sticky_reg;
        out_data_next = out_data_reg;
        out_ovf_next  = out_ovf_reg;

        case (state_reg)
            ACCUM: begin
                if (accept) begin
                    acc_next    = sum;
                    sticky_next = sticky_reg | term_ovf | add_ovf;
                    if (in_last) begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                // A beat accepted here opens a new packet; the held sum is not carried over.
                if (accept) begin
                    acc_next    = term;
                    sticky_next = term_ovf;
                    state_next  = in_last ? HOLD : ACCUM;
                end else if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                if (accept) begin
                    acc_next    = term;
                    sticky_next = term_ovf;
                    state_next  = in_last ? HOLD : ACCUM;
                end
            end
        endcase

        if (accept && in_last) begin
            out_data_next = acc_next;
            out_ovf_next  = sticky_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            acc_reg      <= '0;
            sticky_reg   <= 1'b0;
            out_data_reg <= '0;
            out_ovf_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            acc_reg      <= acc_next;
            sticky_reg   <= sticky_next;
            out_data_reg <= out_data_next;
            out_ovf_reg  <= out_ovf_next;
        end
    end

endmodule
